// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Purpose:
//   Boot-time loader and port owner for the instruction memory. Assembles a
//   byte stream into 32-bit little-endian words and writes them into imem
//   starting at BASE_ADDR. The core is held in stall during the load. When
//   idle, the core fetch address passes straight through to imem.
//
// Optional feature (macro IMEM_LOAD_CHECKSUM_EN):
//   A 32-bit running sum of all written words is kept. One extra 4-byte
//   trailer word follows the last data word. It is never written to memory.
//   done pulses when the trailer equals the sum; otherwise err pulses instead.
//
// Ports:
//   clk        in   rising-edge clock
//   rstN       in   asynchronous active-low reset
//   loadStart  in   load request, sampled only in IDLE
//   loadLen    in   words to load, sampled with loadStart (1..MAX_WORDS legal)
//   byteValid  in   byte stream valid
//   byteData   in   byte stream data
//   byteReady  out  byte stream ready (registered)
//   pcA        in   fetch address from the core
//   memA       out  imem address (pcA in IDLE, else current word address)
//   memWD      out  imem write data (registered)
//   memWE      out  imem write enable (registered, high only in WRITE)
//   cpuStall   out  hold PC/regfile while high (registered)
//   busy       out  high in every state except IDLE (registered)
//   done       out  one-cycle pulse when a load completes (registered)
//   err        out  one-cycle pulse on a rejected request or bad checksum
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           loadStart,
  input  logic [$clog2(MAX_WORDS+1)-1:0] loadLen,
  input  logic                           byteValid,
  input  logic [7:0]                     byteData,
  output logic                           byteReady,
  input  logic [31:0]                    pcA,
  output logic [31:0]                    memA,
  output logic [31:0]                    memWD,
  output logic                           memWE,
  output logic                           cpuStall,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned      LEN_W    = $clog2(MAX_WORDS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      asm_q, asm_d;
  logic [31:0]      mem_wd_q, mem_wd_d;
  logic             mem_we_q, mem_we_d;
  logic             byte_ready_q, byte_ready_d;
  logic             busy_q, busy_d;
  logic             stall_q, stall_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             len_ok_s;
  logic             start_ok_s;
  logic             byte_xfer_s;
  logic             word_done_s;
  logic             last_word_s;
  logic [31:0]      word_s;
  logic [31:0]      word_off_s;
  logic [31:0]      word_addr_s;
  logic             trailer_s;
  logic             cks_bad_s;

  assign len_ok_s    = (loadLen != LEN_ZERO) && (loadLen <= MAX_LEN);
  assign start_ok_s  = (state_q == ST_IDLE) && loadStart && len_ok_s;
  // byteReady is only ever high in LOAD, so this also qualifies the state.
  assign byte_xfer_s = byteValid & byte_ready_q;
  assign word_done_s = byte_xfer_s && (byte_cnt_q == 2'd3);
  assign last_word_s = (word_cnt_q == (len_q - LEN_ONE));
  // Complete word including the byte arriving in this cycle (lane 3).
  assign word_s      = {byteData, asm_q[23:0]};

  // 32-bit address arithmetic, wraps modulo 2^32.
  assign word_off_s  = 32'(word_cnt_q);
  assign word_addr_s = BASE_ADDR + {word_off_s[29:0], 2'b00};

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic HAS_TRAILER = 1'b1;

  logic        trailer_q, trailer_d;
  logic [31:0] sum_q, sum_d;

  assign trailer_s = trailer_q;
  assign cks_bad_s = trailer_q & word_done_s & (word_s != sum_q);

  // Running sum of written words and trailer-phase flag.
  always_comb begin
    sum_d     = sum_q;
    trailer_d = trailer_q;
    case (state_q)
      ST_IDLE: begin
        sum_d     = 32'h0000_0000;
        trailer_d = 1'b0;
      end
      ST_WRITE: begin
        sum_d = sum_q + mem_wd_q;
        if (last_word_s) begin
          trailer_d = 1'b1;
        end else begin
          trailer_d = trailer_q;
        end
      end
      ST_DONE: begin
        trailer_d = 1'b0;
      end
      default: begin
        sum_d     = sum_q;
        trailer_d = trailer_q;
      end
    endcase
  end

  // Checksum state registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sum_q     <= 32'h0000_0000;
      trailer_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      trailer_q <= trailer_d;
    end
  end
`else
  localparam logic HAS_TRAILER = 1'b0;

  assign trailer_s = 1'b0;
  assign cks_bad_s = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= LEN_ZERO;
      len_q        <= LEN_ZERO;
      asm_q        <= 32'h0000_0000;
      mem_wd_q     <= 32'h0000_0000;
      mem_we_q     <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      stall_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      mem_wd_q     <= mem_wd_d;
      mem_we_q     <= mem_we_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      stall_q      <= stall_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (word_done_s) begin
          // The trailer word is checked, never written.
          state_d = trailer_s ? ST_DONE : ST_WRITE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_d = HAS_TRAILER ? ST_LOAD : ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; outputs are decoded from the next state
  // so they are valid in the same cycle as the state they describe.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    asm_d        = asm_q;
    mem_wd_d     = mem_wd_q;
    mem_we_d     = (state_d == ST_WRITE);
    byte_ready_d = (state_d == ST_LOAD);
    busy_d       = (state_d != ST_IDLE);
    stall_d      = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE) & ~cks_bad_s;
    err_d        = ((state_q == ST_IDLE) & loadStart & ~len_ok_s)
                 | ((state_d == ST_DONE) & cks_bad_s);
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          len_d      = loadLen;
          word_cnt_d = LEN_ZERO;
          byte_cnt_d = 2'd0;
        end else begin
          len_d = len_q;
        end
      end
      ST_LOAD: begin
        if (byte_xfer_s) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = byteData;
          // Wraps 3 -> 0 on the fourth byte.
          byte_cnt_d = byte_cnt_q + 2'd1;
          if ((byte_cnt_q == 2'd3) && !trailer_s) begin
            mem_wd_d = word_s;
          end else begin
            mem_wd_d = mem_wd_q;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + LEN_ONE;
      end
      ST_DONE: begin
        byte_cnt_d = 2'd0;
      end
      default: begin
        byte_cnt_d = byte_cnt_q;
      end
    endcase
  end

  assign memA      = (state_q == ST_IDLE) ? pcA : word_addr_s;
  assign memWD     = mem_wd_q;
  assign memWE     = mem_we_q;
  assign byteReady = byte_ready_q;
  assign cpuStall  = stall_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
//
// Self-checking bench for imem_load_ctrl. Inputs are driven on the falling
// edge and outputs sampled there too. Expected memory writes are pushed to a
// scoreboard queue as words are sent and popped when memWE is observed.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 64;
  localparam int          LW   = $clog2(MAXW + 1);

  logic          clk;
  logic          rstN;
  logic          loadStart;
  logic [LW-1:0] loadLen;
  logic          byteValid;
  logic [7:0]    byteData;
  logic          byteReady;
  logic [31:0]   pcA;
  logic [31:0]   memA;
  logic [31:0]   memWD;
  logic          memWE;
  logic          cpuStall;
  logic          busy;
  logic          done;
  logic          err;

  imem_load_ctrl #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .loadStart (loadStart),
    .loadLen   (loadLen),
    .byteValid (byteValid),
    .byteData  (byteData),
    .byteReady (byteReady),
    .pcA       (pcA),
    .memA      (memA),
    .memWD     (memWD),
    .memWE     (memWE),
    .cpuStall  (cpuStall),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          we_cnt   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          done_cyc = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[0:7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "time limit");
  end

  // Advance to the next falling edge; consume observed writes against the
  // scoreboard and count done/err pulses.
  task automatic step();
    logic [63:0] e;
    @(negedge clk);
    if (memWE === 1'b1) begin
      we_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr=%08h data=%08h, required no write", memA, memWD);
      end else begin
        e = exp_q.pop_front();
        if ({memA, memWD} !== e) begin
          n_fail++;
          $display("FAIL write_data: got addr=%08h data=%08h, required addr=%08h data=%08h",
                   memA, memWD, e[63:32], e[31:0]);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err === 1'b1) err_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   k;
    for (int g = 0; g < gap; g++) begin
      byteValid = 1'b0;
      step();
    end
    byteValid = 1'b1;
    byteData  = b;
    k = 0;
    rdy = 1'b0;
    while (!rdy && k < 100) begin
      rdy = byteReady;
      step();
      k++;
    end
    byteValid = 1'b0;
    n_checks++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL byte_handshake: byte %02h not accepted within 100 cycles, required acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      send_byte(b, (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
    end
  endtask

  // Full load of words[0..n-1]; bad_trl sends a wrong checksum trailer.
  task automatic run_load(input int n, input int gap_max, input bit bad_trl);
    logic [31:0] sum;
    int d0, e0, w0, t0, k, lat, exp_done, exp_err;
    sum = 32'h0000_0000;
    d0 = done_cnt;
    e0 = err_cnt;
    w0 = we_cnt;
    loadStart = 1'b1;
    loadLen   = LW'(n);
    step();
    loadStart = 1'b0;
    t0 = cyc;
    n_checks++;
    if ({busy, cpuStall, byteReady} !== 3'b111) begin
      n_fail++;
      $display("FAIL start_flags: got busy/stall/ready=%b, required 111", {busy, cpuStall, byteReady});
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({BASE + 32'(i * 4), words[i]});
      sum = sum + words[i];
      send_word(words[i], gap_max);
    end
    lat      = 5 * n;
    exp_done = 1;
    exp_err  = 0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_word(bad_trl ? sum + 32'h1 : sum, gap_max);
    lat = lat + 4;
    if (bad_trl) begin
      exp_done = 0;
      exp_err  = 1;
    end
`endif
    k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 60) begin
      step();
      k++;
    end
    n_checks++;
    if (done_cnt - d0 !== exp_done) begin
      n_fail++;
      $display("FAIL done_count: got %0d, required %0d", done_cnt - d0, exp_done);
    end
    n_checks++;
    if (err_cnt - e0 !== exp_err) begin
      n_fail++;
      $display("FAIL err_count: got %0d, required %0d", err_cnt - e0, exp_err);
    end
    n_checks++;
    if (we_cnt - w0 !== n) begin
      n_fail++;
      $display("FAIL write_count: got %0d, required %0d", we_cnt - w0, n);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d pending writes, required 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (cpuStall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_in_done: got %b, required 1", cpuStall);
    end
    if (gap_max == 0 && exp_done == 1) begin
      n_checks++;
      if (done_cyc - t0 !== lat) begin
        n_fail++;
        $display("FAIL load_latency: got %0d cycles, required %0d", done_cyc - t0, lat);
      end
    end
    step();
    n_checks++;
    if ({busy, cpuStall, byteReady, done, err} !== 5'b00000 || memA !== pcA) begin
      n_fail++;
      $display("FAIL back_to_idle: got flags=%b memA=%08h, required 00000 memA=%08h",
               {busy, cpuStall, byteReady, done, err}, memA, pcA);
    end
  endtask

  task automatic test_reset();
    rstN      = 1'b0;
    loadStart = 1'b0;
    loadLen   = LW'(0);
    byteValid = 1'b0;
    byteData  = 8'h00;
    pcA       = 32'h0000_0008;
    step();
    step();
    n_checks++;
    if (memA !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL reset_memA: got %08h, required 00000008", memA);
    end
    n_checks++;
    if ({memWE, cpuStall, byteReady, done, err, busy} !== 6'b000000 || memWD !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got flags=%b memWD=%08h, required 000000 memWD=00000000",
               {memWE, cpuStall, byteReady, done, err, busy}, memWD);
    end
    rstN = 1'b1;
    step();
    n_checks++;
    if (memA !== 32'h0000_0008 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got memA=%08h busy=%b, required 00000008 0", memA, busy);
    end
  endtask

  task automatic test_load_back_to_back();
    pcA      = 32'h0000_0100;
    words[0] = 32'h0050_0513;
    words[1] = 32'h0060_0593;
    run_load(2, 0, 1'b0);
  endtask

  task automatic test_load_gaps();
    pcA      = 32'h0000_0204;
    words[0] = 32'h0050_0513;
    words[1] = 32'h0060_0593;
    run_load(2, 3, 1'b0);
  endtask

  task automatic test_bad_len();
    logic [LW-1:0] lens[2];
    lens[0] = LW'(0);
    lens[1] = LW'(MAXW + 1);
    for (int i = 0; i < 2; i++) begin
      loadStart = 1'b1;
      loadLen   = lens[i];
      step();
      loadStart = 1'b0;
      n_checks++;
      if ({err, busy, cpuStall, byteReady} !== 4'b1000) begin
        n_fail++;
        $display("FAIL bad_len_err: len=%0d got err/busy/stall/ready=%b, required 1000",
                 lens[i], {err, busy, cpuStall, byteReady});
      end
      step();
      n_checks++;
      if ({err, busy, cpuStall, done} !== 4'b0000 || memA !== pcA) begin
        n_fail++;
        $display("FAIL bad_len_idle: len=%0d got err/busy/stall/done=%b memA=%08h, required 0000 %08h",
                 lens[i], {err, busy, cpuStall, done}, memA, pcA);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int w0;
    w0 = we_cnt;
    pcA = 32'h0000_0300;
    loadStart = 1'b1;
    loadLen   = LW'(1);
    step();
    loadStart = 1'b0;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rstN = 1'b0;
    #1;
    n_checks++;
    if ({memWE, cpuStall, byteReady, done, err, busy} !== 6'b000000 || memWD !== 32'h0
        || memA !== pcA) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got flags=%b memWD=%08h memA=%08h, required 000000 00000000 %08h",
               {memWE, cpuStall, byteReady, done, err, busy}, memWD, memA, pcA);
    end
    step();
    step();
    rstN = 1'b1;
    step();
    n_checks++;
    if (we_cnt !== w0) begin
      n_fail++;
      $display("FAIL mid_reset_no_write: got %0d writes, required 0", we_cnt - w0);
    end
    words[0] = 32'hCAFE_F00D;
    run_load(1, 0, 1'b0);
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    words[0] = 32'h0000_0001;
    words[1] = 32'h0000_0002;
    run_load(2, 0, 1'b0);
    run_load(2, 1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_load_back_to_back();
    test_load_gaps();
    test_bad_len();
    test_reset_mid_load();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
